ram_arbiter: RTL

- Two-requester arbiter/sequencer in front of the team's 2-port RAM: one write port, one read port, 8-bit address, 4-bit data, 8 entries, 1-cycle registered read, clear on reset.
- Each requester issues single read or write commands over a req/gnt handshake.
- Write port and read port are arbitrated independently, each round-robin, so one write and one read can issue per cycle.
- Drives the RAM's registered command inputs and routes returned read data back to the originating requester.

---
 rtl/ram_arbiter_pkg.sv | 28 ++
 rtl/ram_arbiter_if.sv | 27 ++
 rtl/ram_arbiter_rr_arb2.sv | 41 ++++
 rtl/ram_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants, command/read-tag types and the address range helper for the
// ram_arbiter slice.
package ram_arb_pkg;

   localparam int AW    = 8;
   localparam int DW    = 4;
   localparam int DEPTH = 8;
   localparam int NREQ  = 2;

   localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic valid;
      logic id;
      logic oor;
   } rd_tag_t;

   function automatic logic addr_in_range(input logic [AW-1:0] addr);
      return (addr < DEPTH_A);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester command/grant/response signals plus the RAM command bus of ram_arbiter.
// slave = arbiter side, master = requesters and RAM side.
interface ram_arbiter_if;
   import ram_arb_pkg::*;

   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [DW-1:0] rdata0, rdata1;
   logic          ram_write_en, ram_read_en;
   logic [AW-1:0] ram_write_addr, ram_read_addr;
   logic [DW-1:0] ram_write_data, ram_read_data;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_read_data,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
      output ram_write_en, ram_write_addr, ram_write_data, ram_read_en, ram_read_addr
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_read_data,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
      input  ram_write_en, ram_write_addr, ram_write_data, ram_read_en, ram_read_addr
   );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins at once, on contention the
// pointer-favoured one wins, and any grant hands priority to the other requester.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt[0]) begin
         ptr_d = 1'b1;
      end else if (gnt[1]) begin
         ptr_d = 1'b0;
      end else begin
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters share the 2-port RAM; write and read ports are each
// round-robin arbitrated and read responses are tagged back to their requester.
module ram_arbiter
   import ram_arb_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   ram_arbiter_if.slave  bus
);

   cmd_t          cmd0_s, cmd1_s;
   logic [1:0]    wr_req_s, rd_req_s, wr_gnt_s, rd_gnt_s;
   logic          wr_acc_s, rd_acc_s, wr_id_s, rd_id_s, wr_oor_s, rd_oor_s;
   logic [AW-1:0] wr_addr_s, rd_addr_s;
   logic [DW-1:0] wr_data_s;
   logic [1:0]    rvalid_s;

   logic          wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic [1:0]    err_q, err_d;
   rd_tag_t       tag1_q, tag1_d, tag2_q;

   assign cmd0_s = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
   assign cmd1_s = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};

   assign wr_req_s = {bus.req1 &  cmd1_s.we, bus.req0 &  cmd0_s.we};
   assign rd_req_s = {bus.req1 & ~cmd1_s.we, bus.req0 & ~cmd0_s.we};

   rr_arb2 u_wr_arb (.clk(clk), .rst_n(rst_n), .req(wr_req_s), .gnt(wr_gnt_s));
   rr_arb2 u_rd_arb (.clk(clk), .rst_n(rst_n), .req(rd_req_s), .gnt(rd_gnt_s));

   assign bus.gnt0 = cmd0_s.we ? wr_gnt_s[0] : rd_gnt_s[0];
   assign bus.gnt1 = cmd1_s.we ? wr_gnt_s[1] : rd_gnt_s[1];

   // Grants are one-hot per port, so bit 1 alone identifies the winning requester.
   always_comb begin
      wr_acc_s = |wr_gnt_s;
      rd_acc_s = |rd_gnt_s;
      wr_id_s  = wr_gnt_s[1];
      rd_id_s  = rd_gnt_s[1];
      if (wr_id_s) begin
         wr_addr_s = cmd1_s.addr;
         wr_data_s = cmd1_s.wdata;
      end else begin
         wr_addr_s = cmd0_s.addr;
         wr_data_s = cmd0_s.wdata;
      end
      if (rd_id_s) begin
         rd_addr_s = cmd1_s.addr;
      end else begin
         rd_addr_s = cmd0_s.addr;
      end
      wr_oor_s = ~addr_in_range(wr_addr_s);
      rd_oor_s = ~addr_in_range(rd_addr_s);
   end

   always_comb begin
      wr_en_d   = wr_acc_s & ~wr_oor_s;
      rd_en_d   = rd_acc_s & ~rd_oor_s;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      if (wr_en_d) begin
         wr_addr_d = wr_addr_s;
         wr_data_d = wr_data_s;
      end else begin
         wr_addr_d = wr_addr_q;
         wr_data_d = wr_data_q;
      end
      if (rd_en_d) begin
         rd_addr_d = rd_addr_s;
      end else begin
         rd_addr_d = rd_addr_q;
      end
      err_d[0] = (wr_acc_s & ~wr_id_s & wr_oor_s) | (rd_acc_s & ~rd_id_s & rd_oor_s);
      err_d[1] = (wr_acc_s &  wr_id_s & wr_oor_s) | (rd_acc_s &  rd_id_s & rd_oor_s);
      // Out-of-range reads still take a tag so the requester gets its one rvalid.
      tag1_d   = '{valid: rd_acc_s, id: rd_id_s, oor: rd_oor_s};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= {AW{1'b0}};
         wr_data_q <= {DW{1'b0}};
         rd_en_q   <= 1'b0;
         rd_addr_q <= {AW{1'b0}};
         err_q     <= 2'b00;
         tag1_q    <= 3'b000;
         tag2_q    <= 3'b000;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         err_q     <= err_d;
         tag1_q    <= tag1_d;
         tag2_q    <= tag1_q;
      end
   end

   assign rvalid_s = {tag2_q.valid & tag2_q.id, tag2_q.valid & ~tag2_q.id};

   assign bus.ram_write_en   = wr_en_q;
   assign bus.ram_write_addr = wr_addr_q;
   assign bus.ram_write_data = wr_data_q;
   assign bus.ram_read_en    = rd_en_q;
   assign bus.ram_read_addr  = rd_addr_q;
   assign bus.err0           = err_q[0];
   assign bus.err1           = err_q[1];
   assign bus.rvalid0        = rvalid_s[0];
   assign bus.rvalid1        = rvalid_s[1];
   assign bus.rdata0         = (rvalid_s[0] & ~tag2_q.oor) ? bus.ram_read_data : {DW{1'b0}};
   assign bus.rdata1         = (rvalid_s[1] & ~tag2_q.oor) ? bus.ram_read_data : {DW{1'b0}};

endmodule
